instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the MIPS core: owns the PC, drives the instruction-memory word address and
//  captures the returned instruction into the IF/ID pipeline register.
//  Consumes the async-read instruction memory (addr = PC[6:2]) and feeds decode through a
//  valid/ready handshake. Accepts branch/jump redirects from downstream.
// PARAMETERS
//  PC_WIDTH        32      width of PC and all address/PC outputs
//  IMEM_ADDR_BITS  5       instruction-memory word-address width (32 words)
//  RESET_PC        32'h0   PC value loaded on reset
// PORTS
//  clk            in   1               rising-edge clock
//  rst_n          in   1               asynchronous, active-low reset
//  imem_addr      out  IMEM_ADDR_BITS  = pc[IMEM_ADDR_BITS+1:2], combinational from pc
//  imem_instr     in   32              instruction returned by memory, same cycle (async read)
//  redirect_valid in   1               taken branch/jump this cycle
//  redirect_pc    in   PC_WIDTH        target PC; bits [1:0] ignored
//  id_ready       in   1               decode accepts IF/ID contents this cycle
//  id_valid       out  1               IF/ID register holds a live instruction
//  id_instr       out  32              IF/ID instruction
//  id_pc          out  PC_WIDTH        PC of id_instr
//  id_pc_plus4    out  PC_WIDTH        id_pc + 4 (link/branch base)
//  halted         out  1               fetch permanently stopped (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0,
//   halted=0. Effective immediately, including mid-stall or mid-redirect.
//  "advance" = !id_valid || id_ready. Per rising edge, priority order:
//   1. redirect_valid: pc <= {redirect_pc[PC_WIDTH-1:2],2'b00}; id_valid <= 0 (flush);
//      wins over stall and over a simultaneous advance; id_* data may hold.
//   2. else if !advance: pc and all id_* hold (stall); imem_instr ignored.
//   3. else: id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, pc<=pc+4.
//  Latency: first instruction id_valid=1 after first edge following reset release.
//   Redirect at edge N -> one bubble (id_valid=0) after N; target instr valid after N+1.
//  Arithmetic: pc+4 is modulo 2^PC_WIDTH (wraps 32'hFFFFFFFC -> 0). imem_addr aliases every
//   2^IMEM_ADDR_BITS words (PC 0x80 -> addr 0); no error flag.
//  Handshake: id_* stable while id_valid && !id_ready; transfer occurs on id_valid && id_ready.
//  pc[1:0] always 0.
// CONFIGURATION
//  Macro FETCH_HALT_EN:
//   defined: when rule 3 captures imem_instr == 32'h0000000C (SYSCALL), halted <= 1 on the
//    same edge; that instruction still goes to decode. While halted: pc frozen, no further
//    captures, redirect_valid ignored; id_valid clears once the last instruction is accepted.
//    Only reset clears halted.
//   undefined: halted tied 0; SYSCALL fetched like any other instruction.
// STRUCTURE
//  Shared package mips_pkg: PC_WIDTH, RESET_PC, INSTR_WIDTH=32, NOP=32'h0, SYSCALL=32'h0000000C.
//  One natural sub-module: pc_reg (PC register with reset, load-target, increment, hold).
//  IF/ID register and next-PC priority mux stay in instruction_fetch.
// TESTING
//  1 Reset, id_ready=1, imem=ROM of words i -> id_pc 0,4,8.. one per cycle, id_instr tracks ROM.
//  2 id_ready=0 for 3 cycles at id_pc=8 -> id_pc/id_instr hold 8/ROM[2], pc holds 12, no skip.
//  3 redirect_valid with redirect_pc=0x23, id_ready=0 -> pc=0x20, one bubble, then id_pc=0x20.
//  4 pc=0x7C runs on -> imem_addr 31 then 0 (id_pc=0x80); pc=0xFFFFFFFC -> next pc=0.
//  5 rst_n=0 asynchronously mid-stall -> outputs reset without clock edge; refetch from RESET_PC.
//  6 FETCH_HALT_EN: SYSCALL at word 3 -> halted=1, id_pc=0xC delivered, later redirect ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
//   PC_WIDTH       default width of the PC and PC-derived outputs
//   IMEM_ADDR_BITS default instruction-memory word-address width
//   INSTR_WIDTH    instruction word width
//   RESET_PC       default PC after reset
//   NOP / SYSCALL  instruction encodings that fetch cares about
//   pc_op_e        operation applied to the PC register each cycle
package mips_pkg;

    localparam int          PC_WIDTH       = 32;
    localparam int          IMEM_ADDR_BITS = 5;
    localparam int          INSTR_WIDTH    = 32;
    localparam logic [31:0] RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] NOP            = 32'h0000_0000;
    localparam logic [31:0] SYSCALL        = 32'h0000_000C;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_INC  = 2'd2
    } pc_op_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, loads RESET_VAL
//   op         PC_HOLD / PC_LOAD (take target) / PC_INC (advance one word)
//   target     load value, already word aligned by the caller
//   pc         current PC
//   pc_plus4   pc + 4, modulo 2^W
module pc_reg
    import mips_pkg::*;
#(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  pc_op_e        op,
    input  logic [W-1:0]  target,
    output logic [W-1:0]  pc,
    output logic [W-1:0]  pc_plus4
);

    logic [W-1:0] pc_next;

    // Plain W-bit add: the top word wraps back to zero.
    assign pc_plus4 = pc + W'(4);

    always_comb begin
        pc_next = pc;
        unique case (op)
            PC_LOAD: pc_next = target;
            PC_INC:  pc_next = pc_plus4;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VAL;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, addresses the async-read instruction memory and
// captures the returned word into the IF/ID register, handed to decode over
// a valid/ready handshake. Redirects from downstream flush IF/ID and reload
// the PC.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   - capturing SYSCALL sets halted; fetch then stops for good
//               (PC frozen, redirects ignored) until reset. The SYSCALL
//               itself is still delivered to decode.
//   undefined - halted is tied low and SYSCALL is an ordinary word.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         instruction-memory word address = pc[IMEM_ADDR_BITS+1:2]
//   imem_instr        instruction returned in the same cycle
//   redirect_valid    taken branch/jump this cycle
//   redirect_pc       redirect target, bits [1:0] ignored
//   id_ready          decode accepts IF/ID this cycle
//   id_valid          IF/ID holds a live instruction
//   id_instr, id_pc   IF/ID instruction and its PC
//   id_pc_plus4       id_pc + 4
//   halted            fetch permanently stopped
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                    PC_WIDTH       = mips_pkg::PC_WIDTH,
    parameter int                    IMEM_ADDR_BITS = mips_pkg::IMEM_ADDR_BITS,
    parameter logic [PC_WIDTH-1:0]   RESET_PC       = PC_WIDTH'(mips_pkg::RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [IMEM_ADDR_BITS-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0]     imem_instr,
    input  logic                       redirect_valid,
    input  logic [PC_WIDTH-1:0]        redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [INSTR_WIDTH-1:0]     id_instr,
    output logic [PC_WIDTH-1:0]        id_pc,
    output logic [PC_WIDTH-1:0]        id_pc_plus4,
    output logic                       halted
);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                advance;
    logic                take_redirect;
    logic                capture;
    pc_op_e              pc_op;
    logic                unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign imem_addr            = pc[IMEM_ADDR_BITS+1:2];
    assign advance              = !id_valid || id_ready;

    // Next-PC priority: halt freezes everything, then redirect, then the
    // normal advance; otherwise the stage is stalled and imem is ignored.
    always_comb begin
        take_redirect = 1'b0;
        capture       = 1'b0;
        pc_op         = PC_HOLD;
        if (halted) begin
            pc_op = PC_HOLD;
        end else if (redirect_valid) begin
            take_redirect = 1'b1;
            pc_op         = PC_LOAD;
        end else if (advance) begin
            capture = 1'b1;
            pc_op   = PC_INC;
        end
    end

    pc_reg #(
        .W         (PC_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (pc_op),
        .target   (redirect_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

`ifdef FETCH_HALT_EN
    logic halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (capture && (imem_instr == SYSCALL)) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // IF/ID register. A flush only drops id_valid; the data may hold since
    // decode ignores it while id_valid is low. Once halted, the last word
    // drains out on its handshake and nothing replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (take_redirect) begin
            id_valid <= 1'b0;
        end else if (capture) begin
            id_valid    <= 1'b1;
            id_instr    <= imem_instr;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
        end else if (halted && id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule
